parking_gate_sensor: RTL

- Front end for the lot occupancy counter: turns two raw photo-sensor lines at the gate into single-cycle inc/dec pulses that drive the counter's inc/dec inputs directly.
- Sensor A is the outer beam and sensor B is the inner beam. A car blocks A, then A+B, then B, then neither; direction comes from that order.
- Each input is synchronized and debounced. A direction FSM then accepts only complete, legal sequences, rejecting pedestrians, aborted entries and glitches.

---
 rtl/parking_gate_sensor.sv | 135 +++++++++++++
 1 files changed

// File: rtl/parking_gate_sensor.sv
// Gate sensor front end: synchronizes and debounces the outer (A) and inner (B)
// beams, then turns complete legal A/B sequences into one-cycle inc/dec pulses.
module parking_gate_sensor #(
  parameter int DEBOUNCE = 4,
  parameter int ERRW     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_raw,
  input  logic            b_raw,
  output logic            inc,
  output logic            dec,
  output logic            busy,
  output logic            err,
  output logic [ERRW-1:0] err_cnt
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [2:0] {
    IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAITCLR
  } state_t;

  // Bit 1 carries sensor A and bit 0 sensor B, so r_deb is the FSM's ab pair.
  logic [1:0]    w_raw;
  logic [1:0]    r_sync1, r_sync2, r_prev, r_deb;
  logic [CW-1:0] r_cnt     [2];
  logic [CW-1:0] w_cnt_nxt [2];
  logic [1:0]    w_accept;

  assign w_raw = {a_raw, b_raw};

  // The count is the run length of consecutive samples that disagree with the
  // debounced value; a fresh sync value starts a new run at one.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      // NOTE: defaults first, so every path assigns every output and no latch is inferred.
      w_cnt_nxt[i] = '0;
      w_accept[i]  = 1'b0;
      if (r_sync2[i] != r_deb[i]) begin
        w_cnt_nxt[i] = (r_sync2[i] != r_prev[i]) ? CW'(1) : r_cnt[i] + CW'(1);
        w_accept[i]  = (w_cnt_nxt[i] == CW'(DEBOUNCE));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_prev   <= '0;
      r_deb    <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= w_accept[i] ? '0 : w_cnt_nxt[i];
        if (w_accept[i]) r_deb[i] <= r_sync2[i];
      end
    end
  end

  state_t          r_state;
  logic [1:0]      r_ab_prev;
  logic            r_inc, r_dec, r_err, r_busy;
  logic [ERRW-1:0] r_err_cnt;
  logic            w_changed, w_illegal;

  assign w_changed = (r_deb != r_ab_prev);
  assign w_illegal = w_changed && (r_state != WAITCLR) && ((r_deb ^ r_ab_prev) == 2'b11);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ab_prev <= '0;
      r_inc     <= 1'b0;
      r_dec     <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_inc     <= 1'b0;
      r_dec     <= 1'b0;
      r_err     <= 1'b0;
      r_ab_prev <= r_deb;
      if (w_illegal) begin
        r_state <= WAITCLR;
        r_busy  <= 1'b1;
        r_err   <= 1'b1;
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
      end else if (r_state == WAITCLR) begin
        // Level check, so a diagonal jump straight into 00 recovers next cycle.
        if (r_deb == 2'b00) begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      end else if (w_changed) begin
        // Outside WAITCLR the state mirrors ab, so busy is simply ab != 00.
        r_busy <= (r_deb != 2'b00);
        case (r_state)
          IDLE: if (r_deb == 2'b10) r_state <= EN1;
                else if (r_deb == 2'b01) r_state <= EX1;
          EN1:  if (r_deb == 2'b11) r_state <= EN2;
                else if (r_deb == 2'b00) r_state <= IDLE;
          EN2:  if (r_deb == 2'b01) r_state <= EN3;
                else if (r_deb == 2'b10) r_state <= EN1;
          EN3:  if (r_deb == 2'b00) begin
                  r_state <= IDLE;
                  r_inc   <= 1'b1;
                end else if (r_deb == 2'b11) r_state <= EN2;
          EX1:  if (r_deb == 2'b11) r_state <= EX2;
                else if (r_deb == 2'b00) r_state <= IDLE;
          EX2:  if (r_deb == 2'b10) r_state <= EX3;
                else if (r_deb == 2'b01) r_state <= EX1;
          EX3:  if (r_deb == 2'b00) begin
                  r_state <= IDLE;
                  r_dec   <= 1'b1;
                end else if (r_deb == 2'b11) r_state <= EX2;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign inc     = r_inc;
  assign dec     = r_dec;
  assign err     = r_err;
  assign busy    = r_busy;
  assign err_cnt = r_err_cnt;

endmodule
